// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with a direct-load mode and an
// auto-advancing scan mode with programmable dwell per index.
module decoder_scan #(
  parameter int IN_W = 2,
  parameter int DIV  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_W-1:0]      decoder_in,
  input  logic                 load,
  input  logic                 scan_en,
  input  logic                 enable,
  output logic [(1<<IN_W)-1:0] decoder_out,
  output logic [IN_W-1:0]      index_out,
  output logic                 valid,
  output logic                 wrap
);

  localparam int OUT_W = 1 << IN_W;
  localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(DIV - 1);
  localparam logic [IN_W-1:0] IDX_LAST   = {IN_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  // Next-state: load beats any mode change, which beats a scan advance.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (load) begin
      idx_d   = decoder_in;
      dwell_d = '0;
      state_d = scan_en ? ST_SCAN : ST_DIRECT;
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          if (scan_en) begin
            state_d = ST_SCAN;
            dwell_d = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_SCAN: begin
          if (!scan_en) begin
            state_d = ST_DIRECT;
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            idx_d   = idx_q + IN_W'(1);
            dwell_d = '0;
            wrap_d  = (idx_q == IDX_LAST);
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  // Outputs decode the next index so they land coherent with index_out.
  always_comb begin
    out_d = '0;
    if ((state_d != ST_IDLE) && enable) begin
      out_d[idx_d] = 1'b1;
    end else begin
      out_d = '0;
    end
    valid_d = |out_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dwell_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign decoder_out = out_q;
  assign index_out   = idx_q;
  assign valid       = valid_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: a time-based scan model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_decoder_scan;

  localparam int IN_W = 2;
  localparam int DIV  = 4;
  localparam int NIDX = 1 << IN_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [IN_W-1:0] decoder_in = '0;
  logic            load = 1'b0;
  logic            scan_en = 1'b0;
  logic            enable = 1'b0;
  logic [NIDX-1:0] decoder_out;
  logic [IN_W-1:0] index_out;
  logic            valid;
  logic            wrap;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 direct, 2 scan. In scan the index is
  // base + elapsed/DIV, where elapsed counts cycles since scan (re)start.
  int   m_mode = 0;
  int   m_base = 0;
  int   m_t = 0;
  int   m_idx = 0;
  logic m_wrap = 1'b0;
  logic [NIDX-1:0] tab [NIDX];

  decoder_scan #(.IN_W(IN_W), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .decoder_in(decoder_in), .load(load),
    .scan_en(scan_en), .enable(enable), .decoder_out(decoder_out),
    .index_out(index_out), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int enc(input logic [NIDX-1:0] v);
    int r = 0;
    for (int i = 0; i < NIDX; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic ld, input logic se, input int din);
    if (rst) begin
      m_mode = 0; m_base = 0; m_t = 0; m_idx = 0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (ld) begin
        m_base = din; m_t = 0; m_mode = se ? 2 : 1;
      end else if (m_mode == 2 && !se) begin
        m_base = m_idx; m_t = 0; m_mode = 1;
      end else if (m_mode != 2 && se) begin
        m_base = m_idx; m_t = 0; m_mode = 2;
      end else if (m_mode == 2) begin
        m_t++;
        if ((m_t % DIV) == 0 && ((m_base + m_t / DIV) % NIDX) == 0) m_wrap = 1'b1;
      end
      m_idx = (m_base + m_t / DIV) % NIDX;
    end
  endtask

  // One clock: drive inputs, update the model at the edge, compare at negedge.
  task automatic step(input logic rst, input logic ld, input logic se,
                      input logic en, input int din);
    logic [NIDX-1:0] e_out;
    reset = rst; load = ld; scan_en = se; enable = en;
    decoder_in = IN_W'(din);
    @(posedge clk);
    model_update(rst, ld, se, din);
    e_out = '0;
    if (m_mode != 0 && en) e_out[m_idx] = 1'b1;
    @(negedge clk);
    chk("model_out",   32'(decoder_out), 32'(e_out));
    chk("model_index", 32'(index_out),   32'(m_idx));
    chk("model_valid", 32'(valid),       32'(e_out != '0));
    chk("model_wrap",  32'(wrap),        32'(m_wrap));
  endtask

  initial begin
    tab[0] = 4'b0001; tab[1] = 4'b0010; tab[2] = 4'b0100; tab[3] = 4'b1000;

    // Reset then idle.
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 0);
    chk("reset_out", 32'(decoder_out), 32'h0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("idle_out", 32'(decoder_out), 32'h0);
    chk("idle_valid", 32'(valid), 32'h0);

    // Direct loads on consecutive cycles.
    for (int i = 0; i < NIDX; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, i);
      chk("direct_out", 32'(decoder_out), 32'(tab[i]));
      chk("direct_index", 32'(index_out), 32'(i));
      chk("direct_valid", 32'(valid), 32'h1);
    end

    // Scan from 2 with wrap.
    step(1'b0, 1'b1, 1'b1, 1'b1, 2);
    chk("scan_first", 32'(decoder_out), 32'h4);
    for (int k = 1; k <= 11; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 0);
      if (k == 3) chk("scan_dwell_end", 32'(decoder_out), 32'h4);
      if (k == 4) chk("scan_adv3", 32'(decoder_out), 32'h8);
      if (k == 8) begin
        chk("scan_wrap_out", 32'(decoder_out), 32'h1);
        chk("scan_wrap_pulse", 32'(wrap), 32'h1);
      end
      if (k == 9) chk("scan_wrap_once", 32'(wrap), 32'h0);
    end

    // Load on the pending-advance edge wins.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1);
    chk("load_beats_adv", 32'(decoder_out), 32'h2);
    for (int k = 1; k <= 3; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("load_dwell_hold", 32'(decoder_out), 32'h2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    chk("load_then_adv", 32'(decoder_out), 32'h4);

    // Blanking mid-scan, then scan exit.
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 0);
      chk("blank_out", 32'(decoder_out), 32'h0);
    end
    chk("blank_index", 32'(index_out), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("frozen_out", 32'(decoder_out), 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("frozen_index", 32'(index_out), 32'h3);

    // Load of 0 never pulses wrap; reset mid-dwell clears everything.
    step(1'b0, 1'b1, 1'b1, 1'b1, 0);
    chk("load0_nowrap", 32'(wrap), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 0);
    chk("midreset_out", 32'(decoder_out), 32'h0);
    chk("midreset_index", 32'(index_out), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("post_reset_idle", 32'(valid), 32'h0);

    // Encoder round trip.
    for (int i = 0; i < NIDX; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, i);
      chk("roundtrip_enc", 32'(enc(decoder_out)), 32'(i));
      chk("roundtrip_onehot", 32'($countones(decoder_out)), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
